cond_branch_unit: RTL
=====================

# cond_branch_unit

Program-flow stage directly downstream of the comparison-flag register. Consumes the 12-bit condition vector from that register: bit 11 is always 1, bit 10 is always 0, and bits 9:0 are ALU compare flags. Resolves conditional jump, call and return instructions, owns the program counter and a small return-address stack, and redirects fetch with a one-cycle flush pulse. Detects the flag-update hazard when a CMP is in flight and stalls the branch until the updated flags are visible.

## Interface
Parameters:
- PC_W, 16, program-counter width
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_comp_reg  in  12  condition vector from the comparison-flag register
- i_alu_op  in  4  current ALU opcode; equal to `CMP` means the flags update at the next edge
- i_stall  in  1  global pipeline stall; freezes PC, FSM and RAS
- i_br_valid  in  1  branch instruction present
- i_br_type  in  2  00 JMP, 01 CALL, 10 RET, 11 reserved (treated as not-taken)
- i_cond_sel  in  4  index into i_comp_reg; values 12–15 evaluate as 0
- i_cond_inv  in  1  invert the selected condition
- i_br_target  in  PC_W  jump/call target
- o_br_ready  out  1  branch accepted this cycle when high with i_br_valid
- o_pc  out  PC_W  current fetch PC
- o_flush  out  1  one-cycle pulse: discard younger instructions
- o_ras_err  out  1  sticky; RAS overflow or underflow occurred

## Operation
- Reset values: o_pc=0, o_flush=0, o_ras_err=0, RAS empty, FSM=IDLE.
- PC: when not stalled and no taken branch, o_pc<=o_pc+1, wrapping modulo 2^PC_W (all-ones → 0).
- Condition: take = (i_cond_sel<12 ? i_comp_reg[i_cond_sel] : 0) ^ i_cond_inv. Example: sel=11, inv=0 → always taken; sel=10, inv=0 → never taken.
- FSM states:
  - IDLE: if i_br_valid and i_alu_op==`CMP` and !i_stall, go to WAIT_FLAG with o_br_ready=0. Otherwise o_br_ready=!i_stall.
  - WAIT_FLAG: flags are now updated. If !i_stall, set o_br_ready=1, resolve the branch and return to IDLE. If i_stall, hold.
- Accepted branch (i_br_valid & o_br_ready), by type:
  - JMP taken: o_pc<=i_br_target.
  - CALL taken: push o_pc+1, then o_pc<=i_br_target.
  - RET taken: o_pc<=top of stack, pop.
  - Not-taken (any type): o_pc<=o_pc+1.
- o_flush goes to 1 in the cycle after a taken branch is accepted, for exactly one cycle.
- RAS overflow: CALL with stack full → target still taken, push dropped, o_ras_err<=1.
- RAS underflow: RET with stack empty → not taken (o_pc+1), o_ras_err<=1.
- i_br_valid deasserted while in WAIT_FLAG: return to IDLE with no redirect.
- i_stall has priority over everything: no PC, RAS or FSM change, and o_br_ready=0.

## Timing
- Branch accepted at edge N: o_pc equals the new value after edge N, and o_flush=1 during cycle N+1 only.
- CMP hazard: CMP and branch presented in cycle N → accepted in cycle N+1 using the new flags. Redirect is visible after edge N+1, so resolution latency is 2.
- Back-to-back taken branches each produce their own single-cycle flush pulse.
- Reset mid-WAIT_FLAG or mid-flush: all state returns to its reset value at that edge, and o_flush=0 the following cycle.

## Structure
- Shared package `cb_pkg`:
  - br_type enum (JMP/CALL/RET/RSV)
  - COND_ALWAYS=11, COND_NEVER=10
  - FSM state enum
- `CMP` opcode comes from the existing shared parameter include.
- Sub-module `ras_stack`: push/pop, full/empty flags, top output, synchronous reset to empty, simultaneous push+pop not required.

## Test plan
- Reset, then 5 idle cycles → o_pc = 0,1,2,3,4,5; o_flush stays 0.
- JMP with sel=11 (always), target=0x0040 at PC=3 → o_pc=0x0040 next cycle, single flush pulse. Same with sel=10 → o_pc=4, no flush.
- i_alu_op=`CMP` with i_comp_flag[2]=1 and JMP sel=2 in the same cycle → o_br_ready=0 for one cycle, then taken using the new flags; total latency 2.
- CALL 0x0100 from PC=0x0010, then RET at 0x0105 → o_pc=0x0011 after the RET; five nested CALLs with RAS_DEPTH=4 → o_ras_err=1, first four returns still correct.
- RET on empty stack → o_pc increments, o_ras_err=1 and stays high until reset.
- PC at 0xFFFF → 0x0000. i_stall held for 3 cycles during a pending branch → nothing changes, then the branch resolves normally.

Source files
------------

// File: rtl/cb_pkg.sv
// cb_pkg: shared types and constants for the conditional branch unit.
//   br_type_e : branch kind carried on i_br_type (JMP/CALL/RET/reserved)
//   state_e   : branch-resolution FSM state
//   COND_ALWAYS / COND_NEVER : condition-select indices of the constant
//                              1 and 0 bits of the condition vector
// The ALU CMP opcode normally arrives from the shared parameter include;
// the guarded definition below keeps this slice self-contained.
`ifndef CMP
`define CMP 4'b1010
`endif

package cb_pkg;

    typedef enum logic [1:0] {
        BR_JMP  = 2'b00,
        BR_CALL = 2'b01,
        BR_RET  = 2'b10,
        BR_RSV  = 2'b11
    } br_type_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_FLAG = 1'b1
    } state_e;

    // Bit 11 of the condition vector is tied to 1, bit 10 to 0.
    localparam logic [3:0] COND_ALWAYS = 4'd11;
    localparam logic [3:0] COND_NEVER  = 4'd10;

endpackage

// File: rtl/cb_if.sv
// cb_if: branch request bus between decode and the conditional branch unit.
//   i_comp_reg  : 12-bit condition vector (bit 11 = 1, bit 10 = 0, 9:0 flags)
//   i_alu_op    : opcode in the ALU this cycle (CMP updates flags next edge)
//   i_br_valid  : a branch instruction is presented
//   i_br_type   : 00 JMP, 01 CALL, 10 RET, 11 reserved
//   i_cond_sel  : index into i_comp_reg (12..15 read as 0)
//   i_cond_inv  : invert the selected condition
//   i_br_target : jump/call target
//   o_br_ready  : branch consumer can accept this cycle
// Handshake: a branch is consumed on a rising edge where i_br_valid and
// o_br_ready are both high. While i_br_valid is high and o_br_ready is low
// the producer holds all i_br_* fields stable. o_br_ready may depend on
// i_br_valid and i_alu_op in the same cycle (CMP hazard detection).
interface cb_if #(parameter int PC_W = 16);
    logic [11:0]     i_comp_reg;
    logic [3:0]      i_alu_op;
    logic            i_br_valid;
    logic [1:0]      i_br_type;
    logic [3:0]      i_cond_sel;
    logic            i_cond_inv;
    logic [PC_W-1:0] i_br_target;
    logic            o_br_ready;

    modport master (
        output i_comp_reg, i_alu_op, i_br_valid, i_br_type,
               i_cond_sel, i_cond_inv, i_br_target,
        input  o_br_ready
    );

    modport slave (
        input  i_comp_reg, i_alu_op, i_br_valid, i_br_type,
               i_cond_sel, i_cond_inv, i_br_target,
        output o_br_ready
    );
endinterface

// File: rtl/cond_branch_unit_ras.sv
// ras_stack: return-address stack with synchronous reset to empty.
//   push/push_data : store a return address (ignored when full)
//   pop            : discard the top entry (ignored when empty)
//   top            : current top entry (valid only when !empty)
//   full/empty     : occupancy flags
// Simultaneous push and pop is not used by the branch unit; push wins.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [AW-1:0] top_idx;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    // When full, the low bits of cnt wrap to 0 so cnt-1 still lands on the
    // last slot.
    assign top_idx = cnt[AW-1:0] - AW'(1);
    assign top     = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[cnt[AW-1:0]] <= push_data;
        end
    end
endmodule

// File: rtl/cond_branch_unit.sv
// cond_branch_unit: resolves conditional JMP/CALL/RET, owns the fetch PC and
// the return-address stack, and issues a one-cycle flush on every redirect.
//   clk, reset : clock, synchronous active-high reset
//   br         : branch request bus (cb_if slave)
//   i_stall    : global stall; freezes PC, FSM and RAS, drops o_br_ready
//   o_pc       : current fetch PC
//   o_flush    : high for the one cycle after a taken branch is accepted
//   o_ras_err  : sticky RAS overflow/underflow flag
//   dbg_state  : current FSM state
module cond_branch_unit
    import cb_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    cb_if.slave             br,
    input  logic            i_stall,
    output logic [PC_W-1:0] o_pc,
    output logic            o_flush,
    output logic            o_ras_err,
    output state_e          dbg_state
);
    state_e          state;
    logic [15:0]     cond_vec;
    logic            take;
    logic            hazard;
    logic            ready;
    logic            accept;
    logic            push;
    logic            pop;
    logic            redirect;
    logic            set_err;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] ras_top;
    logic            ras_full;
    logic            ras_empty;

    assign pc_inc    = o_pc + PC_W'(1);
    assign dbg_state = state;

    always_comb begin
        // Zero-extend so selects 12..15 read a constant 0.
        cond_vec = {4'b0000, br.i_comp_reg};
        take     = cond_vec[br.i_cond_sel] ^ br.i_cond_inv;
        // A CMP alongside a branch means the flags it needs land at the next
        // edge; hold the branch one cycle and resolve it from WAIT_FLAG.
        hazard   = (state == ST_IDLE) && br.i_br_valid && (br.i_alu_op == `CMP);
        ready    = !i_stall && !hazard;
        accept   = br.i_br_valid && ready;

        push     = 1'b0;
        pop      = 1'b0;
        redirect = 1'b0;
        set_err  = 1'b0;
        next_pc  = pc_inc;
        if (accept && take) begin
            case (br_type_e'(br.i_br_type))
                BR_JMP: begin
                    next_pc  = br.i_br_target;
                    redirect = 1'b1;
                end
                BR_CALL: begin
                    next_pc  = br.i_br_target;
                    redirect = 1'b1;
                    if (ras_full) set_err = 1'b1;
                    else          push    = 1'b1;
                end
                BR_RET: begin
                    // Underflow degrades to a not-taken branch.
                    if (ras_empty) begin
                        set_err = 1'b1;
                    end else begin
                        next_pc  = ras_top;
                        pop      = 1'b1;
                        redirect = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign br.o_br_ready = ready;

    ras_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            o_pc      <= '0;
            o_flush   <= 1'b0;
            o_ras_err <= 1'b0;
        end else begin
            // redirect is already gated by !i_stall, so a stall in the flush
            // cycle still ends the pulse.
            o_flush <= redirect;
            if (!i_stall) begin
                o_pc      <= next_pc;
                o_ras_err <= o_ras_err | set_err;
                case (state)
                    ST_IDLE:      if (hazard) state <= ST_WAIT_FLAG;
                    ST_WAIT_FLAG: state <= ST_IDLE;
                    default:      state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
